// File: rtl/clken_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
package clken_gen_pkg;

  typedef enum logic {SETTLE, LOCK} state_e;

  localparam int CH_IDX_W = 3;

  // A phase at or beyond the divisor could never match the counter, so it folds to 0.
  function automatic logic [31:0] phase_sel(input logic [31:0] phase, input logic [31:0] div);
    return (phase < div) ? phase : 32'd0;
  endfunction

endpackage

// File: rtl/clken_div_ch.sv
// One enable channel: wrap counter, strobe compare, optional square toggle.
// Square output present only when CLKEN_GEN_SQ_EN is defined.
module clken_div_ch
  import clken_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             lock_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] ph_i,
  output logic             en_o
`ifdef CLKEN_GEN_SQ_EN
  ,
  output logic             sq_o
`endif
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, div_m1;
  logic             div_nz;

  assign div_m1 = div_i - ONE;
  assign div_nz = (div_i != '0);

  // Counter sits at 0 whenever the channel is not actively running in LOCK.
  always_comb begin
    cnt_d = '0;
    if (run_i && div_nz && (cnt_q < div_m1)) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign en_o = lock_i & div_nz & (cnt_q == ph_i);

`ifdef CLKEN_GEN_SQ_EN
  logic [CNT_W-1:0] half_m1;
  logic             sq_q, sq_d;

  assign half_m1 = (div_i >> 1) - ONE;

  always_comb begin
    sq_d = 1'b0;
    if (load_i)                sq_d = div_nz;
    else if (run_i && div_nz) begin
      if (div_i == ONE) sq_d = 1'b1;
      else              sq_d = sq_q ^ ((cnt_q == div_m1) || (cnt_q == half_m1));
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) sq_q <= 1'b0;
    else     sq_q <= sq_d;
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/clken_gen.sv
// Multi-channel clock-enable generator with PLL-style settle/lock and runtime divisors.
// Define CLKEN_GEN_SQ_EN to add registered square-wave outputs.
module clken_gen
  import clken_gen_pkg::*;
#(
  parameter int                         CHANNELS    = 3,
  parameter int                         CNT_W       = 8,
  parameter int                         LOCK_CYCLES = 16,
  parameter logic [CHANNELS*CNT_W-1:0]  DIV_INIT    = {8'd1, 8'd2, 8'd4},
  parameter logic [CHANNELS*CNT_W-1:0]  PHASE       = '0
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                stop,
  input  logic                div_wr,
  input  logic [CH_IDX_W-1:0] div_ch,
  input  logic [CNT_W-1:0]    div_val,
  output logic                div_rdy,
  output logic [CHANNELS-1:0] en,
  output logic                locked
`ifdef CLKEN_GEN_SQ_EN
  ,
  output logic [CHANNELS-1:0] sq
`endif
);

  localparam int                SW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SW-1:0]     LAST = SW'(LOCK_CYCLES - 1);
  localparam logic [CH_IDX_W:0] NCH = (CH_IDX_W+1)'(CHANNELS);

  state_e                             state_q;
  logic [SW-1:0]                      settle_q;
  logic                               locked_q;
  logic [CHANNELS-1:0][CNT_W-1:0]     div_q;
  logic                               accept, enter, leave, run;

  assign accept = div_wr & locked_q & ({1'b0, div_ch} < NCH);
  assign enter  = (state_q == SETTLE) & ~stop & (settle_q == LAST);
  assign leave  = (state_q == LOCK) & (stop | accept);
  assign run    = (state_q == LOCK) & ~leave;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q  <= SETTLE;
      settle_q <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (stop) settle_q <= '0;
          else if (enter) begin
            state_q  <= LOCK;
            locked_q <= 1'b1;
            settle_q <= '0;
          end else settle_q <= settle_q + SW'(1);
        end
        LOCK: begin
          if (leave) begin
            state_q  <= SETTLE;
            locked_q <= 1'b0;
            settle_q <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) div_q <= DIV_INIT;
    else if (accept) begin
      for (int i = 0; i < CHANNELS; i++)
        if (div_ch == CH_IDX_W'(i)) div_q[i] <= div_val;
    end
  end

  assign div_rdy = locked_q;
  assign locked  = locked_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] ph;
    assign ph = CNT_W'(phase_sel(32'(PHASE[g*CNT_W +: CNT_W]), 32'(div_q[g])));

    clken_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clkin  (clkin),
      .rst    (rst),
      .load_i (enter),
      .run_i  (run),
      .lock_i (locked_q),
      .div_i  (div_q[g]),
      .ph_i   (ph),
      .en_o   (en[g])
`ifdef CLKEN_GEN_SQ_EN
      ,
      .sq_o   (sq[g])
`endif
    );
  end

endmodule
